// File: rtl/kamus_fetch_unit_if.sv
// IF-side bus bundle for the kamus fetch unit: instruction-memory port,
// IF->ID instruction stream and the EX redirect.
//
// Handshakes:
//   imem: a request is offered with imem_req_o/imem_addr_o held stable until
//         imem_gnt_i. The accepted request completes with exactly one
//         imem_rvalid_i pulse carrying imem_rdata_i.
//   IF->ID: instr_o/instr_addr_o are valid while instr_valid_o is high. They
//         transfer on a cycle where instr_valid_o && instr_ready_i. Valid
//         does not depend on ready.
interface kamus_fetch_unit_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                imem_req_o;
    logic [PC_WIDTH-1:0] imem_addr_o;
    logic                imem_gnt_i;
    logic                imem_rvalid_i;
    logic [31:0]         imem_rdata_i;
    logic [31:0]         instr_o;
    logic [PC_WIDTH-1:0] instr_addr_o;
    logic                instr_valid_o;
    logic                instr_ready_i;
    logic                redirect_i;
    logic [PC_WIDTH-1:0] redirect_pc_i;

    // Fetch unit side
    modport master (
        output imem_req_o, imem_addr_o, instr_o, instr_addr_o, instr_valid_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        input  redirect_i, redirect_pc_i
    );

    // Memory / decoder / EX side
    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, instr_addr_o, instr_valid_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        output redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/kamus_fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues one word fetch at a time and
// buffers {addr, instr} pairs in a small FIFO that feeds the decoder. A
// redirect flushes the buffer and retires any in-flight fetch as stale.
module kamus_fetch_unit #(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned         FIFO_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    kamus_fetch_unit_if.master bus,
    output logic [1:0]         dbg_state_o
);
    localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                stale_q, stale_d;
    logic [PC_WIDTH-1:0] redirect_pc;

    logic [PC_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [31:0]         fifo_instr_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push, pop, flush, full, empty, credit;

    // Low two bits of the redirect target are dropped to keep fetches word aligned.
    assign redirect_pc = bus.redirect_pc_i & ~PC_WIDTH'(3);

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign flush = bus.redirect_i;
    // A response that races a redirect belongs to the old path and is not kept.
    assign push  = (state_q == WAIT) && bus.imem_rvalid_i && !bus.redirect_i;
    assign pop   = !empty && bus.instr_ready_i && !bus.redirect_i;

    // Occupancy after this cycle's flush/push/pop; used for the credit check.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Only called when nothing is outstanding, so free space after this cycle is the credit.
    assign credit = (count_d < DEPTH_C);

    // Next-state logic for the fetch FSM and the PC/address registers.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_pc_d = req_pc_q;
        stale_d  = stale_q;
        unique case (state_q)
            IDLE: begin
                if (bus.redirect_i) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (credit) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.imem_gnt_i) begin
                    req_pc_d = addr_q;
                    if (bus.redirect_i) begin
                        pc_d    = redirect_pc;
                        state_d = DROP;
                    end else if (stale_q) begin
                        // pc_q already holds the redirect target; do not advance it.
                        state_d = DROP;
                    end else begin
                        pc_d    = pc_q + PC_WIDTH'(4);
                        state_d = WAIT;
                    end
                end else if (bus.redirect_i) begin
                    // The offered request must stay stable, so only remember it is stale.
                    pc_d    = redirect_pc;
                    stale_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus.redirect_i) begin
                    pc_d    = redirect_pc;
                    state_d = bus.imem_rvalid_i ? REQ : DROP;
                end else if (bus.imem_rvalid_i) begin
                    state_d = credit ? REQ : IDLE;
                end
            end
            DROP: begin
                if (bus.redirect_i) begin
                    pc_d = redirect_pc;
                end
                // The stale response retires the outstanding fetch; leave once it lands.
                if (bus.imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DROP || state_d == IDLE) begin
            stale_d = 1'b0;
        end
        // Capture the fetch address only when a new request is first offered.
        if (state_d == REQ && state_q != REQ) begin
            addr_d = pc_d;
        end
    end

    // FSM and PC state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_pc_q <= '0;
            stale_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_pc_q <= req_pc_d;
            stale_q  <= stale_d;
        end
    end

    // Fetch buffer storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i]  <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_addr_q[wr_ptr_q]  <= req_pc_q;
                    fifo_instr_q[wr_ptr_q] <= bus.imem_rdata_i;
                    wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    assign bus.imem_req_o    = (state_q == REQ);
    assign bus.imem_addr_o   = addr_q;
    assign bus.instr_valid_o = !empty;
    assign bus.instr_o       = fifo_instr_q[rd_ptr_q];
    assign bus.instr_addr_o  = fifo_addr_q[rd_ptr_q];
    assign dbg_state_o       = state_q;

    // The credit rule leaves room for every accepted response.
    push_never_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
endmodule
